fwrisc_mem_lsu: RTL and testbench

- Load/store unit: the responder side of the fwrisc memory request interface (req_valid/req_addr/req_op/req_data -> ack_valid).
- Converts each request into one word-aligned data-bus transaction (dvalid/dready), with byte-lane strobes for stores and sign/zero extension for loads.
- Sits between the fwrisc execute stage and the data memory; the fwrisc_mem test driver is its bench initiator and memory model.

---
 rtl/fwrisc_mem_lsu.sv | 208 ++++++++++++++++++++
 tb/tb_fwrisc_mem_lsu.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwrisc_mem_lsu.sv
// fwrisc_mem_lsu: load/store unit, req/ack responder driving a word bus.
// Define FWRISC_MEM_LSU_MISALIGN_CHECK_EN to trap misaligned half/word ops.
module fwrisc_mem_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_data,
    output logic        ack_valid,
    output logic [31:0] ack_data,
    output logic        ack_err,
    output logic        dvalid,
    output logic [31:0] daddr,
    output logic        dwrite,
    output logic [31:0] dwdata,
    output logic [3:0]  dwstb,
    input  logic [31:0] drdata,
    input  logic        dready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LH  = 4'd1;
    localparam logic [3:0] OP_LW  = 4'd2;
    localparam logic [3:0] OP_LBU = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_SB  = 4'd5;
    localparam logic [3:0] OP_SH  = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd7;

    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TMO_LAST =
        TMO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    state_t      state;
    state_t      state_n;

    logic        op_bad;
    logic        op_st;
    logic        mis;
    logic        reject;
    logic [31:0] st_data;
    logic [3:0]  st_stb;

    logic [3:0]  op_q;
    logic [1:0]  k_q;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    logic [31:0] tcnt;
    logic        tmo_hit;

    // Classify the incoming request: invalid op, store, misaligned.
    always_comb begin
        op_bad = req_op[3];
        op_st  = (req_op == OP_SB) || (req_op == OP_SH) ||
                 (req_op == OP_SW);
        mis    = 1'b0;
`ifdef FWRISC_MEM_LSU_MISALIGN_CHECK_EN
        if ((req_op == OP_LH) || (req_op == OP_LHU) ||
            (req_op == OP_SH)) begin
            mis = req_addr[0];
        end
        if ((req_op == OP_LW) || (req_op == OP_SW)) begin
            mis = |req_addr[1:0];
        end
`endif
        reject = op_bad || mis;
    end

    // Replicate store data across lanes and pick byte strobes.
    always_comb begin
        st_data = 32'd0;
        st_stb  = 4'b0000;
        unique case (1'b1)
            (req_op == OP_SB): begin
                st_data = {4{req_data[7:0]}};
                st_stb  = 4'b0001 << req_addr[1:0];
            end
            (req_op == OP_SH): begin
                st_data = {2{req_data[15:0]}};
                st_stb  = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            (req_op == OP_SW): begin
                st_data = req_data;
                st_stb  = 4'b1111;
            end
            default: ;
        endcase
    end

    // Extract and extend the addressed lane of the read data.
    always_comb begin
        ld_byte = drdata[{k_q, 3'b000} +: 8];
        ld_half = k_q[1] ? drdata[31:16] : drdata[15:0];
        ld_data = 32'd0;
        unique case (1'b1)
            (op_q == OP_LB):  ld_data = {{24{ld_byte[7]}}, ld_byte};
            (op_q == OP_LBU): ld_data = {24'd0, ld_byte};
            (op_q == OP_LH):  ld_data = {{16{ld_half[15]}}, ld_half};
            (op_q == OP_LHU): ld_data = {16'd0, ld_half};
            (op_q == OP_LW):  ld_data = drdata;
            default: ;
        endcase
    end

    // Bus-wait counter; only meaningful while a transaction is open.
    always_ff @(posedge clock) begin
        if (reset) begin
            tcnt <= 32'd0;
        end else if (state == S_BUS) begin
            tcnt <= tcnt + 32'd1;
        end else begin
            tcnt <= 32'd0;
        end
    end

    assign tmo_hit = TMO_EN && (state == S_BUS) && (tcnt == TMO_LAST);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state: rejected requests skip the bus; dready beats timeout.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_n = reject ? S_ACK : S_BUS;
                end
            end
            S_BUS: begin
                if (dready || tmo_hit) begin
                    state_n = S_ACK;
                end
            end
            S_ACK:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        dvalid    = (state == S_BUS);
        ack_valid = (state == S_ACK);
    end

    // Bus and ack registers: load on accept, settle on completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            daddr    <= 32'd0;
            dwrite   <= 1'b0;
            dwdata   <= 32'd0;
            dwstb    <= 4'b0000;
            op_q     <= 4'd0;
            k_q      <= 2'd0;
            ack_data <= 32'd0;
            ack_err  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid && reject) begin
                        ack_err  <= 1'b1;
                        ack_data <= 32'd0;
                    end else if (req_valid) begin
                        daddr  <= {req_addr[31:2], 2'b00};
                        dwrite <= op_st;
                        dwdata <= st_data;
                        dwstb  <= st_stb;
                        op_q   <= req_op;
                        k_q    <= req_addr[1:0];
                    end
                end
                S_BUS: begin
                    if (dready || tmo_hit) begin
                        daddr    <= 32'd0;
                        dwrite   <= 1'b0;
                        dwdata   <= 32'd0;
                        dwstb    <= 4'b0000;
                        ack_data <= dready ? ld_data : 32'd0;
                        ack_err  <= ~dready;
                    end
                end
                S_ACK: begin
                    ack_data <= 32'd0;
                    ack_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fwrisc_mem_lsu.sv
// tb_fwrisc_mem_lsu: directed bench with a lane-arithmetic reference model.
// Honours FWRISC_MEM_LSU_MISALIGN_CHECK_EN the same way as the design.
module tb_fwrisc_mem_lsu;

    localparam int TMO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [3:0]  req_op = 4'd0;
    logic [31:0] req_data = 32'd0;
    logic        ack_valid;
    logic [31:0] ack_data;
    logic        ack_err;
    logic        dvalid;
    logic [31:0] daddr;
    logic        dwrite;
    logic [31:0] dwdata;
    logic [3:0]  dwstb;
    logic [31:0] drdata = 32'd0;
    logic        dready = 1'b0;

    fwrisc_mem_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr),
        .req_op(req_op), .req_data(req_data),
        .ack_valid(ack_valid), .ack_data(ack_data),
        .ack_err(ack_err), .dvalid(dvalid), .daddr(daddr),
        .dwrite(dwrite), .dwdata(dwdata), .dwstb(dwstb),
        .drdata(drdata), .dready(dready)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        bad;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  stb;
        logic [31:0] rdat;
    } exp_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_acks = 0;
    int n_dv = 0;
    int ack_cyc = 0;
    int t0 = 0;
    logic [31:0] last_ad = 32'd0;
    logic        last_ae = 1'b0;

    logic        e_chk = 1'b0;
    logic        e_dvalid = 1'b0;
    logic [31:0] e_daddr = 32'd0;
    logic        e_dwrite = 1'b0;
    logic [31:0] e_dwdata = 32'd0;
    logic [3:0]  e_dwstb = 4'd0;
    logic        e_ack = 1'b0;
    logic [31:0] e_ad = 32'd0;
    logic        e_ae = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference: lanes by shift/mask arithmetic, sign by range test.
    function automatic exp_t model(input logic [3:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] d,
                                   input logic [31:0] rd);
        exp_t m;
        int unsigned k;
        int unsigned h;
        logic [31:0] b;
        logic [31:0] hw;
        m = '0;
        k = 32'(a[1:0]);
        h = 32'(a[1]);
        m.addr = a & 32'hFFFF_FFFC;
        m.bad = (op > 4'd7);
`ifdef FWRISC_MEM_LSU_MISALIGN_CHECK_EN
        if ((op == 4'd1 || op == 4'd4 || op == 4'd6) && a[0]) m.bad = 1'b1;
        if ((op == 4'd2 || op == 4'd7) && a[1:0] != 2'd0) m.bad = 1'b1;
`endif
        b = (rd >> (8 * k)) & 32'hFF;
        hw = (rd >> (16 * h)) & 32'hFFFF;
        case (op)
            4'd0: m.rdat = (b >= 32'd128) ? b - 32'd256 : b;
            4'd1: m.rdat = (hw >= 32'd32768) ? hw - 32'd65536 : hw;
            4'd2: m.rdat = rd;
            4'd3: m.rdat = b;
            4'd4: m.rdat = hw;
            4'd5: begin
                m.wr = 1'b1;
                m.wdata = (d & 32'hFF) * 32'h0101_0101;
                m.stb = 4'(1 << k);
            end
            4'd6: begin
                m.wr = 1'b1;
                m.wdata = (d & 32'hFFFF) * 32'h0001_0001;
                m.stb = 4'(3 << (2 * h));
            end
            4'd7: begin
                m.wr = 1'b1;
                m.wdata = d;
                m.stb = 4'hF;
            end
            default: ;
        endcase
        if (m.bad) m.rdat = 32'd0;
        return m;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Compare process: every cycle against the timeline expectations.
    always @(negedge clock) begin
        if (e_chk) begin
            chk("dvalid", 32'(dvalid), 32'(e_dvalid));
            chk("ack_valid", 32'(ack_valid), 32'(e_ack));
            chk("ack_err", 32'(ack_err), 32'(e_ae));
            chk("ack_data", ack_data, e_ad);
            if (e_dvalid) begin
                chk("daddr", daddr, e_daddr);
                chk("dwrite", 32'(dwrite), 32'(e_dwrite));
                chk("dwstb", 32'(dwstb), 32'(e_dwstb));
                if (e_dwrite) chk("dwdata", dwdata, e_dwdata);
            end
        end
        if (dvalid) n_dv++;
        if (ack_valid) begin
            n_acks++;
            ack_cyc = cyc;
            last_ad = ack_data;
            last_ae = ack_err;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_exp();
        e_dvalid = 1'b0;
        e_ack = 1'b0;
        e_ad = 32'd0;
        e_ae = 1'b0;
    endtask

    // One request: nw wait cycles before dready, hold stretches dready.
    task automatic run(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] rd,
                       input int nw, input bit hold);
        exp_t m;
        bit done;
        int i;
        m = model(op, addr, data, rd);
        t0 = cyc;
        req_valid = 1'b1;
        req_op = op;
        req_addr = addr;
        req_data = data;
        dready = 1'b0;
        drdata = ~rd;
        idle_exp();
        step();
        if (m.bad) begin
            e_ack = 1'b1;
            e_ae = 1'b1;
            e_ad = 32'd0;
        end else begin
            done = 1'b0;
            i = 0;
            while (!done) begin
                e_dvalid = 1'b1;
                e_daddr = m.addr;
                e_dwrite = m.wr;
                e_dwdata = m.wdata;
                e_dwstb = m.stb;
                dready = (i == nw);
                drdata = dready ? rd : ~rd;
                done = (i == nw) || (i == TMO - 1);
                step();
                i++;
            end
            e_dvalid = 1'b0;
            e_ack = 1'b1;
            e_ae = (nw > TMO - 1);
            e_ad = e_ae ? 32'd0 : m.rdat;
            dready = hold;
            drdata = ~rd;
        end
        step();
        req_valid = 1'b0;
        dready = 1'b0;
        idle_exp();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0;
        int d0;
        exp_t pm;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        idle_exp();
        e_chk = 1'b1;
        chk("rst_dvalid", 32'(dvalid), 32'd0);
        chk("rst_ack", 32'(ack_valid), 32'd0);
        chk("rst_daddr", daddr, 32'd0);
        chk("rst_dwstb", 32'(dwstb), 32'd0);
        chk("rst_dwdata", dwdata, 32'd0);
        chk("rst_dwrite", 32'(dwrite), 32'd0);
        step();

        pm = model(4'd0, 32'h2001, 32'd0, 32'h1234_F678);
        chk("model_lb", pm.rdat, 32'hFFFF_FFF6);
        pm = model(4'd1, 32'h2002, 32'd0, 32'h8001_7FFF);
        chk("model_lh", pm.rdat, 32'hFFFF_8001);
        pm = model(4'd6, 32'h2002, 32'h0000_BEEF, 32'd0);
        chk("model_sh_stb", 32'(pm.stb), 32'hC);
        chk("model_sh_data", pm.wdata, 32'hBEEF_BEEF);

        run(4'd5, 32'h1003, 32'h0000_00A5, 32'd0, 0, 1'b0);
        chk("sb_lat", 32'(ack_cyc - t0), 32'd2);
        chk("sb_ackdata", last_ad, 32'd0);
        run(4'd0, 32'h2001, 32'd0, 32'h1234_F678, 3, 1'b0);
        chk("lb_lit", last_ad, 32'hFFFF_FFF6);
        chk("lb_lat", 32'(ack_cyc - t0), 32'd5);
        run(4'd3, 32'h2001, 32'd0, 32'h1234_F678, 3, 1'b0);
        chk("lbu_lit", last_ad, 32'h0000_00F6);
        run(4'd1, 32'h2002, 32'd0, 32'h8001_7FFF, 1, 1'b0);
        chk("lh_lit", last_ad, 32'hFFFF_8001);
        run(4'd4, 32'h2002, 32'd0, 32'h8001_7FFF, 0, 1'b0);
        chk("lhu_lit", last_ad, 32'h0000_8001);
        run(4'd6, 32'h2002, 32'h1234_BEEF, 32'd0, 0, 1'b0);
        run(4'd6, 32'h2000, 32'h0000_0102, 32'd0, 1, 1'b0);
        run(4'd7, 32'h5004, 32'h1122_3344, 32'd0, 2, 1'b0);
        run(4'd5, 32'h5000, 32'h0000_1177, 32'd0, 0, 1'b0);
        run(4'd0, 32'h6000, 32'd0, 32'h0000_0080, 0, 1'b0);
        chk("lb0_lit", last_ad, 32'hFFFF_FF80);
        run(4'd3, 32'h6003, 32'd0, 32'h7F00_0000, 0, 1'b0);
        chk("lbu3_lit", last_ad, 32'h0000_007F);
        run(4'd1, 32'h6000, 32'd0, 32'h0000_7FFF, 0, 1'b0);
        chk("lh0_lit", last_ad, 32'h0000_7FFF);

        a0 = n_acks;
        run(4'd2, 32'h7000, 32'd0, 32'hA5A5_0001, 0, 1'b1);
        run(4'd2, 32'h7004, 32'd0, 32'h5A5A_0002, 2, 1'b0);
        chk("b2b_acks", 32'(n_acks - a0), 32'd2);
        chk("b2b_lit", last_ad, 32'h5A5A_0002);
        step();

        d0 = n_dv;
        run(4'd9, 32'h0, 32'd0, 32'd0, 0, 1'b0);
        chk("badop_lat", 32'(ack_cyc - t0), 32'd1);
        chk("badop_err", 32'(last_ae), 32'd1);
        chk("badop_nodv", 32'(n_dv - d0), 32'd0);

        d0 = n_dv;
        run(4'd2, 32'h8000, 32'd0, 32'h1111_2222, 99, 1'b0);
        chk("tmo_err", 32'(last_ae), 32'd1);
        chk("tmo_dvcycles", 32'(n_dv - d0), 32'(TMO));
        chk("tmo_lat", 32'(ack_cyc - t0), 32'(TMO + 1));

        run(4'd2, 32'h3002, 32'd0, 32'hCAFE_F00D, 0, 1'b0);
`ifdef FWRISC_MEM_LSU_MISALIGN_CHECK_EN
        chk("mis_err", 32'(last_ae), 32'd1);
`else
        chk("mis_lit", last_ad, 32'hCAFE_F00D);
`endif

        a0 = n_acks;
        req_valid = 1'b1;
        req_op = 4'd2;
        req_addr = 32'h4000;
        dready = 1'b0;
        idle_exp();
        step();
        e_dvalid = 1'b1;
        e_daddr = 32'h4000;
        e_dwrite = 1'b0;
        e_dwstb = 4'd0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_valid = 1'b0;
        dready = 1'b1;
        idle_exp();
        chk("rstmid_dvalid", 32'(dvalid), 32'd0);
        step();
        dready = 1'b0;
        repeat (3) step();
        chk("rstmid_noack", 32'(n_acks - a0), 32'd0);

        e_chk = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
